fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences instruction fetch for the RISC-V core. Owns the program counter, issues one request at a time to instruction memory, buffers the returned word, and hands it to decode with its PC. Branch, jump and trap redirects from execute replace the PC at any point, and any stale in-flight fetch is discarded.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h0000_0000`: PC loaded by reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: fetch address; always equals `pc_out`.
- `imem_rsp_valid` in 1: read data valid, one-cycle pulse.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode consumes instruction.
- `inst_data` out 32: buffered instruction.
- `inst_pc` out 32: PC of `inst_data`.
- `redirect_valid` in 1: branch or jump taken.
- `redirect_target` in 32: branch or jump target.
- `trap_valid` in 1: trap or exception entry.
- `trap_target` in 32: trap handler address.
- `pc_out` out 32: current fetch PC.

## Operation
States: RST, REQ, WAIT, HOLD, DRAIN.
- **RST**: entered asynchronously on `reset`. `pc_out = RESET_VECTOR`. Advances to REQ on the first edge after release.
- **REQ**: `imem_req_valid = 1`. Moves to WAIT when `imem_req_ready` is high.
- **WAIT**: on `imem_rsp_valid`, captures `inst_data <= imem_rsp_data` and `inst_pc <= pc_out`, then moves to HOLD.
- **HOLD**: `inst_valid = 1`. On `inst_ready`, sets `pc <= pc + 4` (mod 2^32, wraps from `FFFF_FFFC` to `0`) and moves to REQ.
- **DRAIN**: waits for the outstanding response, drops it, then moves to REQ.

Redirects:
- A redirect is `trap_valid | redirect_valid`.
- Target: `trap_target` if `trap_valid`, else `redirect_target`. Trap wins when both are asserted.
- Target bits [1:0] are forced to 0.
- The redirect loads `pc` on the same edge in every state except RST.

Next state on a redirect:
- REQ with `imem_req_ready = 0` -> REQ.
- REQ with `imem_req_ready = 1` -> DRAIN.
- WAIT with no response this cycle -> DRAIN.
- WAIT with a response this cycle -> REQ; the response is dropped.
- HOLD -> REQ; the held instruction is dropped even if `inst_ready` is high.
- DRAIN -> DRAIN. If the pending response arrives in the same cycle, go to REQ instead.

Other rules:
- `inst_data` and `inst_pc` hold their values outside HOLD. `inst_data` resets to 0.
- A response arriving in REQ or HOLD is a protocol error. It is ignored.

## Timing
- **Reset values**: `imem_req_valid = 0`, `inst_valid = 0`, `pc_out = imem_req_addr = RESET_VECTOR`, `inst_pc = RESET_VECTOR`, `inst_data = 0`.
- **First request**: `imem_req_valid` rises in cycle 1 after reset release.
- **Response timing**: the memory responds no earlier than the cycle after acceptance.
- **Decode latency**: response in cycle N gives `inst_valid` in cycle N+1.
- **Next request**: consume in cycle M gives the next request in cycle M+1.
- **Throughput**: best case is one instruction per 3 cycles.
- **Redirect latency**: redirect in cycle K gives `imem_req_addr = target` in cycle K+1. The request goes out in cycle K+1, or after the drain completes.
- **Address changes**: `imem_req_addr` may change while `imem_req_valid` is high only because of a redirect. The memory interface tolerates this before acceptance.
- All outputs are driven from registers or from state decode. There is no combinational path from any input to any output.

## Structure
- **Shared package `fetch_pkg`**: state enum (`ST_RST`, `ST_REQ`, `ST_WAIT`, `ST_HOLD`, `ST_DRAIN`), `INST_BYTES = 4`, `XLEN = 32`.
- **Sub-module `next_pc_sel`** (combinational): priority select of trap / redirect / pc+4 / hold, with alignment masking.
- All registers live in `fetch_sequencer`.

## Test plan
- **Reset and straight-line fetch**: release reset with 1-cycle memory -> requests at `0x0`, `0x4`, `0x8`; `inst_pc` matches each; one instruction every 3 cycles.
- **Decode backpressure**: `inst_ready = 0` for 5 cycles in HOLD -> `inst_valid` and `inst_data` stable; no new request; `pc_out` unchanged.
- **Redirect during WAIT, late response**: redirect to `0x100` in WAIT, memory responds 2 cycles later -> state DRAIN, response dropped, then request at `0x100`; decode never sees the stale word.
- **Simultaneous trap and redirect in HOLD**: `trap_target = 0x80`, `redirect_target = 0x200`, `inst_ready = 1` -> next request at `0x80`; held instruction not counted as consumed.
- **Misaligned target and wrap**: redirect to `0x103` -> request at `0x100`. PC `0xFFFF_FFFC` consumed -> next request at `0x0000_0000`.
- **Reset mid-operation**: assert `reset` in WAIT -> all outputs return to reset values immediately (asynchronous); a late response after release is ignored; the first request is at `RESET_VECTOR`.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } fetch_state_t;

   // Instructions are word aligned; the low two target bits are discarded.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_next_pc_sel.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : next_pc_sel
// Brief  : Priority select of the next PC: trap, redirect, sequential, hold.
// Rev    : 1.0
//------------------------------------------------------------------------------
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_advance,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_target,
   input  logic            i_trap_valid,
   input  logic [XLEN-1:0] i_trap_target,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_next_pc
);

   logic [XLEN-1:0] w_seq_pc;

   // Natural 32-bit wrap from the top word back to address zero.
   assign w_seq_pc   = i_pc + XLEN'(INST_BYTES);
   assign o_redirect = i_trap_valid | i_redirect_valid;

   always_comb begin
      o_next_pc = i_pc;
      if (i_trap_valid) begin
         o_next_pc = align_pc(i_trap_target);
      end else if (i_redirect_valid) begin
         o_next_pc = align_pc(i_redirect_target);
      end else if (i_advance) begin
         o_next_pc = w_seq_pc;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_sequencer
// Brief  : Owns the PC, issues one instruction fetch at a time, hands the
//          returned word to decode, and squashes stale fetches on redirect.
// Rev    : 1.0
//------------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
)
(
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] pc_out
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst_data;
   logic [XLEN-1:0] r_inst_pc;
   logic            r_req_valid;
   logic            r_inst_valid;

   logic            w_redirect;
   logic            w_advance;
   logic            w_capture;
   logic [XLEN-1:0] w_next_pc;

   assign w_advance = (r_state == ST_HOLD) && inst_ready;
   assign w_capture = (r_state == ST_WAIT) && imem_rsp_valid && !w_redirect;

   next_pc_sel u_next_pc_sel (
      .i_pc              (r_pc),
      .i_advance         (w_advance),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .i_trap_valid      (trap_valid),
      .i_trap_target     (trap_target),
      .o_redirect        (w_redirect),
      .o_next_pc         (w_next_pc)
   );

   // A response seen in REQ or HOLD cannot belong to us and is ignored.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RST: begin
            w_state_next = ST_REQ;
         end
         ST_REQ: begin
            if (imem_req_ready) begin
               w_state_next = w_redirect ? ST_DRAIN : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               w_state_next = w_redirect ? ST_REQ : ST_HOLD;
            end else if (w_redirect) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (w_redirect || inst_ready) begin
               w_state_next = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem_rsp_valid) begin
               w_state_next = ST_REQ;
            end
         end
         default: begin
            w_state_next = ST_RST;
         end
      endcase
   end

   // Handshake flags are registered alongside the state so no input reaches
   // an output combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RST;
         r_pc         <= RESET_VECTOR;
         r_inst_data  <= '0;
         r_inst_pc    <= RESET_VECTOR;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_req_valid  <= (w_state_next == ST_REQ);
         r_inst_valid <= (w_state_next == ST_HOLD);
         if (r_state != ST_RST) begin
            r_pc <= w_next_pc;
         end
         if (w_capture) begin
            r_inst_data <= imem_rsp_data;
            r_inst_pc   <= r_pc;
         end
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_pc;
   assign pc_out         = r_pc;
   assign inst_valid     = r_inst_valid;
   assign inst_data      = r_inst_data;
   assign inst_pc        = r_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_fetch_sequencer
// Brief  : Randomized scoreboard bench for fetch_sequencer with a memory model.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic [31:0] pc_out;

   int          n_cmp = 0;
   int          n_bad = 0;

   exp_t        sb_q[$];
   exp_t        m_e;
   logic [31:0] exp_pc;

   bit          mem_pend = 0;
   logic [31:0] mem_addr;
   int          mem_cnt;

   int          k_acc_pct, k_ready_pct, k_redir_pct, k_dmin, k_dmax;
   bit          f_redir = 0, f_trap = 0;
   logic [31:0] f_rt, f_tt;
   int          f_ready = -1;

   bit          s_acc;
   logic        s_req_valid, s_inst_valid;
   logic [31:0] s_pc, s_inst_data;

   bit          run_mon = 0;
   bit          tput_on = 0;
   int          cyc = 0;
   int          last_cons = -1;

   fetch_sequencer #(.RESET_VECTOR(RV)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_target     (trap_target),
      .pc_out          (pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_t e;
      exp_pc = RV;
      e.pc   = RV;
      e.data = mem_word(RV);
      sb_q.delete();
      sb_q.push_back(e);
   endtask

   // One clock of stimulus: memory model, decode, redirects, reference model.
   task automatic cycle();
      logic        rv, tv;
      logic [31:0] rt, tt;
      exp_t        e;
      @(posedge clk);
      #1;
      s_req_valid  = imem_req_valid;
      s_inst_valid = inst_valid;
      s_pc         = pc_out;
      s_inst_data  = inst_data;
      s_acc        = 0;

      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pend       = 0;
         end else begin
            mem_cnt--;
         end
      end
      imem_req_ready = !mem_pend && ($urandom_range(99) < k_acc_pct);
      if (s_req_valid && imem_req_ready) begin
         mem_pend = 1;
         mem_addr = imem_req_addr;
         mem_cnt  = int'($urandom_range(k_dmax, k_dmin));
         s_acc    = 1;
      end

      inst_ready = (f_ready >= 0) ? (f_ready == 1) : ($urandom_range(99) < k_ready_pct);

      rv = 0; tv = 0; rt = $urandom; tt = $urandom;
      if (f_redir || f_trap) begin
         rv = f_redir; tv = f_trap; rt = f_rt; tt = f_tt;
      end else if ($urandom_range(99) < k_redir_pct) begin
         rv = 1'($urandom_range(1));
         tv = !rv || ($urandom_range(3) == 0);
         if ($urandom_range(3) == 0) rt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         if ($urandom_range(3) == 0) tt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      end
      redirect_valid  = rv;
      trap_valid      = tv;
      redirect_target = rt;
      trap_target     = tt;

      if (rv || tv) begin
         exp_pc = (tv ? tt : rt) & ~32'h3;
         sb_q.delete();
         e.pc = exp_pc; e.data = mem_word(exp_pc);
         sb_q.push_back(e);
      end else if (s_inst_valid && inst_ready) begin
         exp_pc = exp_pc + 32'd4;
         e.pc = exp_pc; e.data = mem_word(exp_pc);
         sb_q.push_back(e);
      end

      f_redir = 0; f_trap = 0; f_ready = -1;
   endtask

   task automatic wait_inst_valid(input string tag);
      int n = 0;
      do begin cycle(); n++; end while (!s_inst_valid && n < 40);
      if (!s_inst_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: inst_valid never rose within 40 cycles", tag);
      end
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      do begin cycle(); n++; end while (!s_acc && n < 40);
      if (!s_acc) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no request accepted within 40 cycles", tag);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_valid"},  {31'd0, imem_req_valid}, 32'd0);
      check({tag, "_inst_valid"}, {31'd0, inst_valid},     32'd0);
      check({tag, "_pc_out"},     pc_out,                  RV);
      check({tag, "_req_addr"},   imem_req_addr,           RV);
      check({tag, "_inst_pc"},    inst_pc,                 RV);
      check({tag, "_inst_data"},  inst_data,               32'd0);
   endtask

   // Monitor: pops the scoreboard on every consumed instruction.
   always @(negedge clk) begin
      if (!reset && run_mon) begin
         cyc++;
         check("addr_eq_pc", imem_req_addr, pc_out);
         if (imem_req_valid && !redirect_valid && !trap_valid)
            check("req_addr", imem_req_addr, exp_pc);
         if (inst_valid && inst_ready && !redirect_valid && !trap_valid) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL consume: instruction pc %08h with no expected entry", inst_pc);
            end else begin
               m_e = sb_q.pop_front();
               check("inst_pc", inst_pc, m_e.pc);
               check("inst_data", inst_data, m_e.data);
            end
            if (tput_on && last_cons >= 0)
               check("throughput", 32'(cyc - last_cons), 32'd3);
            last_cons = cyc;
         end
      end
   end

   initial begin
      #500000;
      n_cmp++; n_bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          seen;
      logic [31:0] held_data, held_pc;
      reset = 1'b1;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
      inst_ready = 0; redirect_valid = 0; redirect_target = '0;
      trap_valid = 0; trap_target = '0;
      k_acc_pct = 100; k_ready_pct = 100; k_redir_pct = 0; k_dmin = 1; k_dmax = 1;
      model_reset();

      // Reset values, then release and expect the first request one cycle later.
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      #1;
      reset = 1'b0;
      run_mon = 1;
      check("cycle0_req_valid", {31'd0, imem_req_valid}, 32'd0);

      tput_on = 1; last_cons = -1;
      cycle();
      check("first_req_valid", {31'd0, s_req_valid}, 32'd1);
      check("first_req_addr", s_pc, RV);
      repeat (12) cycle();
      tput_on = 0;

      // Decode backpressure: HOLD must be frozen.
      k_ready_pct = 0;
      wait_inst_valid("backpressure");
      held_data = s_inst_data;
      held_pc   = s_pc;
      repeat (5) begin
         cycle();
         check("bp_inst_valid", {31'd0, s_inst_valid}, 32'd1);
         check("bp_inst_data", s_inst_data, held_data);
         check("bp_no_req", {31'd0, s_req_valid}, 32'd0);
         check("bp_pc", s_pc, held_pc);
      end
      k_ready_pct = 100;

      // Redirect in WAIT, response 2 cycles later -> drain then fetch 0x100.
      k_dmin = 3; k_dmax = 3;
      wait_accept("wait_redirect");
      f_redir = 1; f_rt = 32'h0000_0100;
      cycle();
      k_dmin = 1; k_dmax = 1;
      cycle();
      check("drain_no_req_a", {31'd0, s_req_valid}, 32'd0);
      check("drain_pc", s_pc, 32'h0000_0100);
      cycle();
      check("drain_no_req_b", {31'd0, s_req_valid}, 32'd0);
      cycle();
      check("drain_req_valid", {31'd0, s_req_valid}, 32'd1);
      check("drain_req_addr", s_pc, 32'h0000_0100);
      repeat (6) cycle();

      // Trap and redirect together in HOLD with decode ready: trap wins.
      k_ready_pct = 0;
      wait_inst_valid("trap_hold");
      f_trap = 1; f_tt = 32'h0000_0080;
      f_redir = 1; f_rt = 32'h0000_0200;
      f_ready = 1;
      cycle();
      k_ready_pct = 100;
      cycle();
      check("trap_req_valid", {31'd0, s_req_valid}, 32'd1);
      check("trap_req_addr", s_pc, 32'h0000_0080);
      check("trap_inst_dropped", {31'd0, s_inst_valid}, 32'd0);
      repeat (6) cycle();

      // Misaligned target, then wrap past the top of the address space.
      f_redir = 1; f_rt = 32'h0000_0103;
      cycle();
      cycle();
      check("misaligned_pc", s_pc, 32'h0000_0100);
      repeat (6) cycle();
      f_redir = 1; f_rt = 32'hFFFF_FFFC;
      cycle();
      seen = 0;
      repeat (20) begin
         cycle();
         if (s_req_valid && s_pc == 32'h0) seen = 1;
      end
      check("wrap_req_zero", {31'd0, seen}, 32'd1);

      // Randomized traffic.
      k_acc_pct = 70; k_ready_pct = 70; k_redir_pct = 8; k_dmin = 1; k_dmax = 4;
      repeat (3000) cycle();
      k_redir_pct = 0; k_acc_pct = 100; k_ready_pct = 100;
      repeat (10) cycle();

      // Asynchronous reset while WAIT, then a late stale response.
      k_dmin = 3; k_dmax = 3;
      wait_accept("reset_mid");
      cycle();
      #3;
      reset = 1'b1;
      run_mon = 0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      cycle();
      #1;
      reset = 1'b0;
      run_mon = 1;
      k_dmin = 1; k_dmax = 1;
      cycle();
      check("rst_first_req_valid", {31'd0, s_req_valid}, 32'd1);
      check("rst_first_req_addr", s_pc, RV);
      repeat (15) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
